ysyx_24100029_ras_ckpt: RTL and testbench
=========================================

Name: ysyx_24100029_ras_ckpt

Overview:
Parametrised return address stack with speculative checkpoint/repair for the IFU branch predictor. Calls push and returns pop/peek. Each predicted branch takes a snapshot so a mispredict can restore the pointer, the count and the top entry in one cycle. Adds overflow wrap, same-cycle pop+push (coroutine return) and underflow reporting.

Parameters:
DEPTH, 8, stack entries; power of two, at least 2.
AW, 32, return address width.
NCKPT, 4, checkpoint slots; power of two, at least 2.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
push_i  in  1  call: push push_addr_i
push_addr_i  in  AW  return address to push
pop_i  in  1  return: pop top entry
top_o  out  AW  current top entry, combinational; 0 when top_valid_o=0
top_valid_o  out  1  count != 0
ckpt_i  in  1  take a checkpoint of post-update state
ckpt_ready_o  out  1  at least one slot free
ckpt_id_o  out  $clog2(NCKPT)  slot allocated if ckpt_i fires this cycle (lowest free index)
restore_i  in  1  mispredict: restore slot restore_id_i
restore_id_i  in  $clog2(NCKPT)  slot to restore
release_i  in  1  branch resolved correct: free release_id_i
release_id_i  in  $clog2(NCKPT)  slot to free
overflow_o  out  1  registered 1-cycle pulse: push while full
underflow_o  out  1  registered 1-cycle pulse: pop while empty

Behaviour:
- State: sp ($clog2(DEPTH) bits, wraps modulo DEPTH), count (0..DEPTH), LIFO[DEPTH] (not reset), slot busy bits, slot payload {sp, count, top entry}.
- Reset: sp=0, count=0, all slots free. Outputs after reset: top_o=0, top_valid_o=0, ckpt_ready_o=1, ckpt_id_o=0, overflow_o=0, underflow_o=0.
- top_o = LIFO[sp-1] (mod DEPTH) when count>0.
- Priority per cycle: restore_i > (push/pop) ; release_i independent; ckpt_i dropped when restore_i=1 or ckpt_ready_o=0.
- Push only: LIFO[sp]<=addr; sp+1; count+1 saturating at DEPTH. If count==DEPTH, the oldest entry is overwritten; overflow_o=1 next cycle.
- Pop only, count>0: sp-1, count-1. Pop with count==0: no state change; underflow_o=1 next cycle.
- Push+pop, count>0: LIFO[sp-1]<=addr; sp and count unchanged. Push+pop, count==0: treated as push only, no underflow.
- Checkpoint: ckpt_i && ckpt_ready_o && !restore_i stores {sp_next, count_next, top entry after this cycle's push/pop} into slot ckpt_id_o and sets it busy. Visible to restore from the next cycle.
- Restore: sp<=slot.sp, count<=slot.count, LIFO[slot.sp-1]<=slot.top when slot.count>0 (repairs a top entry clobbered after the snapshot). All slots are freed: the in-order core resolves branches oldest-first, so the mispredicted branch is the oldest outstanding. Same-cycle push/pop/ckpt are discarded. Restore of a non-busy slot is illegal and covered by an assertion; the RTL then ignores it.
- Release: frees the slot. Releasing a free slot is a no-op. Release and ckpt of the same slot in one cycle: allocation wins, so the slot ends busy.
- Latency: push/pop/restore are visible on top_o on the cycle after the edge. No stalls; no handshake beyond ckpt_ready_o.
- Reset has priority over everything. Reset mid-speculation discards all slots.

Decomposition:
- Package ysyx_24100029_ras_pkg:
  - parametrised typedef ras_ckpt_t {sp, count, top}.
  - localparam widths derived from DEPTH/NCKPT.
  - enum for op decode {NOP, PUSH, POP, REPLACE}.
- Sub-module ysyx_24100029_ras_ckpt_file:
  - slot storage, busy vector, lowest-free priority encoder, release/restore freeing.
- Top holds the LIFO, sp/count and the op decode.

Test Plan:
- Push 0x8000_0010, 0x8000_0020, 0x8000_0030, then pop ×3 -> top_o 0x30, 0x20, 0x10; after the last pop top_valid_o=0 and top_o=0. A fourth pop -> underflow_o pulses one cycle, count stays 0.
- DEPTH=8: push 9 addresses A1..A9 -> overflow_o pulses once on the 9th. Pop ×8 -> A9..A2; then top_valid_o=0.
- Push A, B; ckpt (id 0); pop; push C -> top=C. Restore id 0 -> top=B, count=2. Pop -> A.
- Push A; push+pop same cycle with D -> top=D, count=1. Push+pop with count=0 -> behaves as push, no underflow.
- Take 4 ckpts -> ids 0,1,2,3 and ckpt_ready_o=0; a 5th ckpt_i is ignored. Release 2 -> ckpt_id_o=2. Restore 0 -> all slots free, ckpt_id_o=0.
- Restore with push_i=1 in the same cycle -> push dropped, state equals the snapshot. Reset asserted with 3 busy slots -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ysyx_24100029_ras_pkg.sv
// Shared widths, checkpoint payload type and op decode for the return address stack.
package ysyx_24100029_ras_pkg;

   localparam int DEPTH = 8;
   localparam int AW    = 32;
   localparam int NCKPT = 4;

   localparam int SPW  = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int IDW  = $clog2(NCKPT);

   typedef struct packed {
      logic [SPW-1:0]  sp;
      logic [CNTW-1:0] count;
      logic [AW-1:0]   top;
   } ras_ckpt_t;

   typedef enum logic [1:0] {NOP, PUSH, POP, REPLACE} ras_op_e;

   // A push+pop on an empty stack degenerates to a plain push.
   function automatic ras_op_e decode_op(logic push, logic pop, logic empty);
      if (push && pop && !empty) return REPLACE;
      if (push)                  return PUSH;
      if (pop)                   return POP;
      return NOP;
   endfunction

endpackage

// File: rtl/ysyx_24100029_ras_ckpt_if.sv
// Stack, checkpoint and status signals between the branch predictor and the RAS.
// ckpt_i is a valid qualified by ckpt_ready_o: a checkpoint is taken only in a
// cycle where both are high and restore_i is low; all other inputs are unqualified.
interface ysyx_24100029_ras_ckpt_if import ysyx_24100029_ras_pkg::*; ();

   logic           push_i;
   logic [AW-1:0]  push_addr_i;
   logic           pop_i;
   logic [AW-1:0]  top_o;
   logic           top_valid_o;
   logic           ckpt_i;
   logic           ckpt_ready_o;
   logic [IDW-1:0] ckpt_id_o;
   logic           restore_i;
   logic [IDW-1:0] restore_id_i;
   logic           release_i;
   logic [IDW-1:0] release_id_i;
   logic           overflow_o;
   logic           underflow_o;

   modport master (
      output push_i, push_addr_i, pop_i, ckpt_i, restore_i, restore_id_i,
             release_i, release_id_i,
      input  top_o, top_valid_o, ckpt_ready_o, ckpt_id_o, overflow_o, underflow_o
   );

   modport slave (
      input  push_i, push_addr_i, pop_i, ckpt_i, restore_i, restore_id_i,
             release_i, release_id_i,
      output top_o, top_valid_o, ckpt_ready_o, ckpt_id_o, overflow_o, underflow_o
   );

endinterface

// File: rtl/ysyx_24100029_ras_ckpt_file.sv
// Checkpoint slot storage with busy bits and lowest-free-index allocation.
module ysyx_24100029_ras_ckpt_file import ysyx_24100029_ras_pkg::*; (
   input  logic           clock,
   input  logic           reset,
   input  logic           alloc_i,
   input  ras_ckpt_t      alloc_data_i,
   input  logic           release_i,
   input  logic [IDW-1:0] release_id_i,
   input  logic           clear_i,
   input  logic [IDW-1:0] rd_id_i,
   output logic           ready_o,
   output logic [IDW-1:0] free_id_o,
   output ras_ckpt_t      rd_slot_o,
   output logic           rd_busy_o
);

   logic [NCKPT-1:0] busy_q, busy_d;
   ras_ckpt_t        slot_q [NCKPT];

   always_comb begin
      free_id_o = '0;
      for (int i = NCKPT - 1; i >= 0; i--) begin
         if (!busy_q[i]) free_id_o = IDW'(i);
      end
   end

   assign ready_o   = |(~busy_q);
   assign rd_slot_o = slot_q[rd_id_i];
   assign rd_busy_o = busy_q[rd_id_i];

   // Allocation is applied after release so a same-slot release loses.
   always_comb begin
      busy_d = busy_q;
      if (release_i) busy_d[release_id_i] = 1'b0;
      if (alloc_i)   busy_d[free_id_o]    = 1'b1;
      if (clear_i)   busy_d               = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   always_ff @(posedge clock) begin
      if (!reset && alloc_i) slot_q[free_id_o] <= alloc_data_i;
   end

endmodule

// File: rtl/ysyx_24100029_ras_ckpt.sv
// Return address stack with wrap-on-overflow and one-cycle checkpoint repair.
module ysyx_24100029_ras_ckpt import ysyx_24100029_ras_pkg::*; (
   input  logic                      clock,
   input  logic                      reset,
   ysyx_24100029_ras_ckpt_if.slave   bus
);

   localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

   logic [SPW-1:0]  sp_q, sp_d, sp_m1, sp_m2;
   logic [CNTW-1:0] count_q, count_d;
   logic            ovf_q, ovf_d, unf_q, unf_d;
   logic [AW-1:0]   lifo_q [DEPTH];
   logic            lifo_we;
   logic [SPW-1:0]  lifo_waddr;
   logic [AW-1:0]   lifo_wdata;
   logic            empty, full;
   logic [AW-1:0]   top_cur, top_next;
   ras_op_e         op;
   logic            ckpt_fire, restore_fire, file_ready, rd_busy;
   logic [IDW-1:0]  free_id;
   ras_ckpt_t       rd_slot, snap;

   assign sp_m1   = sp_q - SPW'(1);
   assign sp_m2   = sp_q - SPW'(2);
   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL);
   assign top_cur = empty ? '0 : lifo_q[sp_m1];
   assign op      = decode_op(bus.push_i, bus.pop_i, empty);

   always_comb begin
      sp_d       = sp_q;
      count_d    = count_q;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      lifo_we    = 1'b0;
      lifo_waddr = sp_q;
      lifo_wdata = bus.push_addr_i;
      top_next   = top_cur;
      if (bus.restore_i) begin
         // Rewrite the snapshot's top in case it was clobbered after the snapshot.
         if (rd_busy) begin
            sp_d       = rd_slot.sp;
            count_d    = rd_slot.count;
            lifo_we    = (rd_slot.count != '0);
            lifo_waddr = rd_slot.sp - SPW'(1);
            lifo_wdata = rd_slot.top;
         end
      end else begin
         case (op)
            PUSH: begin
               lifo_we  = 1'b1;
               sp_d     = sp_q + SPW'(1);
               top_next = bus.push_addr_i;
               if (full) ovf_d   = 1'b1;
               else      count_d = count_q + CNTW'(1);
            end
            POP: begin
               if (empty) begin
                  unf_d = 1'b1;
               end else begin
                  sp_d     = sp_m1;
                  count_d  = count_q - CNTW'(1);
                  top_next = (count_q == CNTW'(1)) ? '0 : lifo_q[sp_m2];
               end
            end
            REPLACE: begin
               lifo_we    = 1'b1;
               lifo_waddr = sp_m1;
               top_next   = bus.push_addr_i;
            end
            default: ;
         endcase
      end
   end

   assign restore_fire = bus.restore_i & rd_busy;
   assign ckpt_fire    = bus.ckpt_i & file_ready & ~bus.restore_i;
   assign snap         = '{sp: sp_d, count: count_d, top: top_next};

   always_ff @(posedge clock) begin
      if (reset) begin
         sp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && lifo_we) lifo_q[lifo_waddr] <= lifo_wdata;
   end

   ysyx_24100029_ras_ckpt_file u_file (
      .clock        (clock),
      .reset        (reset),
      .alloc_i      (ckpt_fire),
      .alloc_data_i (snap),
      .release_i    (bus.release_i),
      .release_id_i (bus.release_id_i),
      .clear_i      (restore_fire),
      .rd_id_i      (bus.restore_id_i),
      .ready_o      (file_ready),
      .free_id_o    (free_id),
      .rd_slot_o    (rd_slot),
      .rd_busy_o    (rd_busy)
   );

   assign bus.top_o        = top_cur;
   assign bus.top_valid_o  = ~empty;
   assign bus.ckpt_ready_o = file_ready;
   assign bus.ckpt_id_o    = free_id;
   assign bus.overflow_o   = ovf_q;
   assign bus.underflow_o  = unf_q;

   restore_of_busy_slot: assert property (
      @(posedge clock) disable iff (reset) bus.restore_i |-> rd_busy
   );

endmodule

// File: tb/tb_ysyx_24100029_ras_ckpt.sv
// Directed and random stimulus for the RAS, checked against a cycle-level stack model.
module tb_ysyx_24100029_ras_ckpt;
   import ysyx_24100029_ras_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clock = ~clock;

   ysyx_24100029_ras_ckpt_if bus ();

   ysyx_24100029_ras_ckpt dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Model: circular buffer with pointer/count, and a slot table of snapshots.
   logic [31:0] m_mem [DEPTH];
   int          m_sp, m_count;
   bit          m_busy [NCKPT];
   int          s_sp [NCKPT];
   int          s_count [NCKPT];
   logic [31:0] s_top [NCKPT];
   bit          m_ovf, m_unf;

   function automatic logic [31:0] m_top();
      return (m_count > 0) ? m_mem[(m_sp + DEPTH - 1) % DEPTH] : 32'h0;
   endfunction

   function automatic int m_free();
      for (int i = 0; i < NCKPT; i++) if (!m_busy[i]) return i;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit push, input logic [31:0] addr, input bit pop,
                             input bit ck, input bit rs, input int rsid,
                             input bit rl, input int rlid, input bit rst);
      int fid;
      fid = m_free();
      m_ovf = 0;
      m_unf = 0;
      if (rst) begin
         m_sp = 0;
         m_count = 0;
         for (int i = 0; i < NCKPT; i++) m_busy[i] = 0;
      end else if (rs) begin
         if (m_busy[rsid]) begin
            m_sp = s_sp[rsid];
            m_count = s_count[rsid];
            if (m_count > 0) m_mem[(m_sp + DEPTH - 1) % DEPTH] = s_top[rsid];
            for (int i = 0; i < NCKPT; i++) m_busy[i] = 0;
         end
      end else begin
         if (push && pop && m_count > 0) begin
            m_mem[(m_sp + DEPTH - 1) % DEPTH] = addr;
         end else if (push) begin
            m_mem[m_sp] = addr;
            m_sp = (m_sp + 1) % DEPTH;
            if (m_count == DEPTH) m_ovf = 1;
            else m_count++;
         end else if (pop) begin
            if (m_count > 0) begin
               m_sp = (m_sp + DEPTH - 1) % DEPTH;
               m_count--;
            end else begin
               m_unf = 1;
            end
         end
         if (rl) m_busy[rlid] = 0;
         if (ck && fid >= 0) begin
            s_sp[fid] = m_sp;
            s_count[fid] = m_count;
            s_top[fid] = m_top();
            m_busy[fid] = 1;
         end
      end
   endtask

   task automatic cyc(input bit push, input logic [31:0] addr, input bit pop,
                      input bit ck, input bit rs, input int rsid,
                      input bit rl, input int rlid, input bit rst);
      int fid;
      reset            = rst;
      bus.push_i       = push;
      bus.push_addr_i  = addr;
      bus.pop_i        = pop;
      bus.ckpt_i       = ck;
      bus.restore_i    = rs;
      bus.restore_id_i = IDW'(rsid);
      bus.release_i    = rl;
      bus.release_id_i = IDW'(rlid);
      model_step(push, addr, pop, ck, rs, rsid, rl, rlid, rst);
      @(posedge clock);
      #1;
      fid = m_free();
      chk("top", bus.top_o, m_top());
      chk("top_valid", 32'(bus.top_valid_o), 32'(m_count > 0));
      chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow_o), 32'(m_unf));
      chk("ckpt_ready", 32'(bus.ckpt_ready_o), 32'(fid >= 0));
      if (fid >= 0) chk("ckpt_id", 32'(bus.ckpt_id_o), 32'(fid));
   endtask

   task automatic t_push(input logic [31:0] a);  cyc(1, a, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic t_pop();                       cyc(0, 0, 1, 0, 0, 0, 0, 0, 0); endtask
   task automatic t_idle();                      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic t_ckpt();                      cyc(0, 0, 0, 1, 0, 0, 0, 0, 0); endtask
   task automatic t_restore(input int id);       cyc(0, 0, 0, 0, 1, id, 0, 0, 0); endtask
   task automatic t_release(input int id);       cyc(0, 0, 0, 0, 0, 0, 1, id, 0); endtask

   initial begin
      bit p, q, c, r, l, x;
      int rid, lid, busy_n;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      m_sp = 0;
      m_count = 0;
      for (int i = 0; i < NCKPT; i++) m_busy[i] = 0;

      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("rst_top", bus.top_o, 32'h0);
      chk("rst_ready", 32'(bus.ckpt_ready_o), 32'd1);

      // Basic push/pop and underflow.
      t_push(32'h8000_0010);
      t_push(32'h8000_0020);
      t_push(32'h8000_0030);
      chk("tp1_top30", bus.top_o, 32'h8000_0030);
      t_pop();
      chk("tp1_top20", bus.top_o, 32'h8000_0020);
      t_pop();
      chk("tp1_top10", bus.top_o, 32'h8000_0010);
      t_pop();
      chk("tp1_empty_valid", 32'(bus.top_valid_o), 32'd0);
      t_pop();
      chk("tp1_underflow", 32'(bus.underflow_o), 32'd1);
      t_idle();
      chk("tp1_underflow_clr", 32'(bus.underflow_o), 32'd0);

      // Overflow wraps over the oldest entry.
      for (int i = 1; i <= 9; i++) t_push(32'h1000_0000 + 32'(i) * 4);
      chk("tp2_overflow", 32'(bus.overflow_o), 32'd1);
      for (int i = 9; i >= 2; i--) begin
         chk("tp2_pop_top", bus.top_o, 32'h1000_0000 + 32'(i) * 4);
         t_pop();
      end
      chk("tp2_drained", 32'(bus.top_valid_o), 32'd0);

      // Checkpoint and repair of a clobbered top.
      t_push(32'hA);
      t_push(32'hB);
      chk("tp3_id0", 32'(bus.ckpt_id_o), 32'd0);
      t_ckpt();
      t_pop();
      t_push(32'hC);
      chk("tp3_top_c", bus.top_o, 32'hC);
      t_restore(0);
      chk("tp3_restored_b", bus.top_o, 32'hB);
      t_pop();
      chk("tp3_pop_a", bus.top_o, 32'hA);
      t_pop();

      // Same-cycle push+pop.
      t_push(32'hA);
      cyc(1, 32'hD, 1, 0, 0, 0, 0, 0, 0);
      chk("tp4_replace", bus.top_o, 32'hD);
      t_pop();
      cyc(1, 32'hE, 1, 0, 0, 0, 0, 0, 0);
      chk("tp4_empty_pp_top", bus.top_o, 32'hE);
      chk("tp4_empty_pp_unf", 32'(bus.underflow_o), 32'd0);
      t_pop();

      // Slot allocation order, exhaustion, release and restore freeing.
      for (int i = 0; i < NCKPT; i++) begin
         chk("tp5_alloc_id", 32'(bus.ckpt_id_o), 32'(i));
         t_ckpt();
      end
      chk("tp5_full", 32'(bus.ckpt_ready_o), 32'd0);
      t_ckpt();
      t_release(2);
      chk("tp5_rel_id", 32'(bus.ckpt_id_o), 32'd2);
      t_restore(0);
      chk("tp5_restore_id", 32'(bus.ckpt_id_o), 32'd0);

      // Restore discards a same-cycle push; reset discards busy slots.
      t_push(32'h1111);
      t_ckpt();
      t_push(32'h2222);
      cyc(1, 32'h3333, 0, 0, 1, 0, 0, 0, 0);
      chk("tp6_restore_push", bus.top_o, 32'h1111);
      t_ckpt();
      t_ckpt();
      t_ckpt();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("tp6_rst_valid", 32'(bus.top_valid_o), 32'd0);
      chk("tp6_rst_id", 32'(bus.ckpt_id_o), 32'd0);

      // Random traffic with only legal restores.
      for (int n = 0; n < 1500; n++) begin
         p = ($urandom_range(0, 2) != 0);
         q = ($urandom_range(0, 2) == 0);
         c = ($urandom_range(0, 3) == 0);
         l = ($urandom_range(0, 3) == 0);
         lid = int'($urandom_range(0, NCKPT - 1));
         x = ($urandom_range(0, 299) == 0);
         busy_n = 0;
         for (int i = 0; i < NCKPT; i++) if (m_busy[i]) busy_n++;
         r = (busy_n > 0) && ($urandom_range(0, 9) == 0);
         rid = 0;
         if (r) begin
            do rid = int'($urandom_range(0, NCKPT - 1)); while (!m_busy[rid]);
         end
         cyc(p, $urandom, q, c, r, rid, l, lid, x);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
